// File: rtl/result_writeback.sv
// Buffers one serialized result tile and writes it to data memory over a req/gnt port.
// Optional WB_PACK_EN: pack two 16-bit elements per 32-bit memory write.
module result_writeback #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 5,
    parameter int SEGMENTS = 16,
    parameter int MAWIDTH  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [AWIDTH-1:0]  in_addr,
    input  logic [DWIDTH-1:0]  in_data,
    input  logic               in_finish,
    input  logic [MAWIDTH-1:0] base_addr,
    output logic               mem_req,
    output logic [MAWIDTH-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_wstrb,
    input  logic               mem_gnt,
    output logic               wb_busy,
    output logic               wb_done,
    output logic [2:0]         wb_err
);

`ifdef WB_PACK_EN
    localparam int NWRITES = (SEGMENTS + 1) / 2;
`else
    localparam int NWRITES = SEGMENTS;
`endif
    localparam int IW = $clog2(NWRITES + 1);
    localparam int SW = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [DWIDTH-1:0]         buf_q [SEGMENTS];
    logic [DWIDTH-1:0]         buf_d [SEGMENTS];
    logic [SEGMENTS-1:0]       written_q, written_d;
    logic [MAWIDTH-1:0]        base_q, base_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [2:0]                err_q, err_d;
    logic                      inRange;
    logic [SW-1:0]             inSel;

    assign inRange = 32'(in_addr) < SEGMENTS;
    assign inSel   = SW'(in_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            written_q <= '0;
            base_q    <= '0;
            idx_q     <= '0;
            err_q     <= '0;
            for (int i = 0; i < SEGMENTS; i++) buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            written_q <= written_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            for (int i = 0; i < SEGMENTS; i++) buf_q[i] <= buf_d[i];
        end
    end

    // written_d already includes a beat coincident with in_finish, so the completeness test sees it.
    always_comb begin
        state_d   = state_q;
        written_d = written_q;
        base_d    = base_q;
        idx_d     = idx_q;
        err_d     = err_q;
        for (int i = 0; i < SEGMENTS; i++) buf_d[i] = buf_q[i];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    base_d    = base_addr;
                    written_d = '0;
                    err_d     = '0;
                    for (int i = 0; i < SEGMENTS; i++) buf_d[i] = '0;
                    if (inRange) begin
                        buf_d[inSel]     = in_data;
                        written_d[inSel] = 1'b1;
                    end else begin
                        err_d[0] = 1'b1;
                    end
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    if (inRange) begin
                        buf_d[inSel]     = in_data;
                        written_d[inSel] = 1'b1;
                    end else begin
                        err_d[0] = 1'b1;
                    end
                end
                if (in_finish) begin
                    if (!(&written_d)) err_d[2] = 1'b1;
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (in_valid) err_d[1] = 1'b1;
                if (mem_gnt) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IW'(NWRITES - 1)) state_d = DONE;
                end
            end
            DONE: begin
                if (in_valid) err_d[1] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_PACK_EN
    logic [SW-1:0] loSel, hiSel;
    logic          hiValid;
    assign loSel   = SW'(2 * 32'(idx_q));
    assign hiSel   = SW'(2 * 32'(idx_q) + 1);
    assign hiValid = (2 * 32'(idx_q) + 1) < SEGMENTS;
`else
    logic [SW-1:0] dSel;
    assign dSel = SW'(idx_q);
`endif

    // Outputs derive only from registered state, so they hold steady through grant stalls.
    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (state_q == DRAIN) begin
            mem_req   = 1'b1;
            mem_addr  = base_q + (MAWIDTH'(idx_q) << 2);
            mem_wstrb = 4'b1111;
`ifdef WB_PACK_EN
            mem_wdata[15:0] = 16'(buf_q[loSel]);
            if (hiValid) mem_wdata[31:16] = 16'(buf_q[hiSel]);
            else         mem_wstrb = 4'b0011;
`else
            mem_wdata = 32'($signed(buf_q[dSel]));
`endif
        end
    end

    assign wb_busy = (state_q == CAPTURE) || (state_q == DRAIN);
    assign wb_done = (state_q == DONE);
    assign wb_err  = err_q;

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: expected writes are queued at in_finish and
// checked against the memory port every cycle mem_req is high.
module tb_result_writeback;

    localparam int SEG = 16;
`ifdef WB_PACK_EN
    localparam int NW = (SEG + 1) / 2;
`else
    localparam int NW = SEG;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    logic        clk = 0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_addr;
    logic [15:0] in_data;
    logic        in_finish;
    logic [31:0] base_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        wb_busy;
    logic        wb_done;
    logic [2:0]  wb_err;

    result_writeback #(.DWIDTH(16), .AWIDTH(5), .SEGMENTS(SEG), .MAWIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_finish(in_finish), .base_addr(base_addr), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .wb_busy(wb_busy),
        .wb_done(wb_done), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int          errCount = 0;
    int          checkCount = 0;
    int          popCount = 0;
    wr_t         expQ[$];
    logic [15:0] model [SEG];
    logic [SEG-1:0] modelWritten;
    logic [31:0] modelBase;
    logic [2:0]  expErr = 0;
    bit          tileOpen = 0;
    bit          gntToggle = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1 mem_gnt = gntToggle ? ~mem_gnt : 1'b1;
    end

    // Every cycle the port requests, it must present the oldest outstanding expected write.
    always @(negedge clk) begin
        if (!rst && mem_req) begin
            checkOutput("reqExpected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                checkOutput("memAddr", 64'(mem_addr), 64'(expQ[0].a));
                checkOutput("memWdata", 64'(mem_wdata), 64'(expQ[0].d));
                checkOutput("memWstrb", 64'(mem_wstrb), 64'(expQ[0].s));
                if (mem_gnt) begin
                    void'(expQ.pop_front());
                    popCount++;
                end
            end
        end
    end

    task automatic applyStimulus(input int idx, input logic [15:0] data);
        if (!tileOpen) begin
            for (int i = 0; i < SEG; i++) model[i] = '0;
            modelWritten = '0;
            modelBase = base_addr;
            expErr = '0;
            tileOpen = 1;
        end
        if (idx < SEG) begin
            model[idx] = data;
            modelWritten[idx] = 1'b1;
        end else begin
            expErr[0] = 1'b1;
        end
        in_valid = 1;
        in_addr = 5'(idx);
        in_data = data;
        tick();
        in_valid = 0;
    endtask

    task automatic pulseFinish();
        wr_t w;
        if (!(&modelWritten)) expErr[2] = 1'b1;
        for (int k = 0; k < NW; k++) begin
            w.a = modelBase + 32'(4 * k);
`ifdef WB_PACK_EN
            w.d = {((2 * k + 1) < SEG) ? model[2 * k + 1] : 16'h0, model[2 * k]};
            w.s = ((2 * k + 1) < SEG) ? 4'hF : 4'h3;
`else
            w.d = {{16{model[k][15]}}, model[k]};
            w.s = 4'hF;
`endif
            expQ.push_back(w);
        end
        tileOpen = 0;
        in_finish = 1;
        tick();
        in_finish = 0;
    endtask

    task automatic waitDone(input bit checkLatency);
        int n = 0;
        bit seen = 0;
        for (n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (wb_done) begin
                seen = 1;
                break;
            end
        end
        checkOutput("doneSeen", 64'(seen), 64'd1);
        if (seen) begin
            if (checkLatency) checkOutput("doneLatency", 64'(n), 64'(NW + 1));
            checkOutput("errAtDone", 64'(wb_err), 64'(expErr));
            checkOutput("busyAtDone", 64'(wb_busy), 64'd0);
            @(negedge clk);
            checkOutput("donePulseLen", 64'(wb_done), 64'd0);
            checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
        end
        tick();
    endtask

    task automatic fullTile(input logic [31:0] base, input logic [15:0] seed);
        base_addr = base;
        for (int i = 0; i < SEG; i++) applyStimulus(i, seed + 16'(i));
    endtask

    initial begin
        int startPops;
        rst = 1; in_valid = 0; in_addr = 0; in_data = 0; in_finish = 0;
        base_addr = 0; mem_gnt = 1;
        repeat (3) tick();
        rst = 0;
        checkOutput("rstReq", 64'(mem_req), 64'd0);
        checkOutput("rstAddr", 64'(mem_addr), 64'd0);
        checkOutput("rstData", 64'(mem_wdata), 64'd0);
        checkOutput("rstBusy", 64'(wb_busy), 64'd0);
        checkOutput("rstDone", 64'(wb_done), 64'd0);
        checkOutput("rstErr", 64'(wb_err), 64'd0);

        // Finish with no beats in IDLE is ignored.
        in_finish = 1; tick(); in_finish = 0; tick();
        checkOutput("idleFinishBusy", 64'(wb_busy), 64'd0);

        // Full tile, constant grant.
        gntToggle = 0;
        fullTile(32'h1000, 16'd1);
        checkOutput("captureBusy", 64'(wb_busy), 64'd1);
        pulseFinish();
        waitDone(1);

        // Same tile with grant toggling.
        gntToggle = 1;
        fullTile(32'h1000, 16'd1);
        pulseFinish();
        waitDone(0);

        // Negative element sign extension.
        gntToggle = 0;
        base_addr = 32'h2000;
        for (int i = 0; i < SEG; i++) applyStimulus(i, (i == 5) ? 16'hFFFE : 16'h0100 + 16'(i));
        pulseFinish();
        waitDone(1);

        // Incomplete tile plus out-of-range index, last beat coincident with finish.
        base_addr = 32'h3000;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(i, 16'h8000 + 16'(i));
            if (i == 6) applyStimulus(20, 16'h7777);
        end
        model[13] = 16'h8013; modelWritten[13] = 1'b1;
        in_valid = 1; in_addr = 5'd13; in_data = 16'h8013;
        pulseFinish();
        in_valid = 0;
        waitDone(1);

        // Reset in the middle of a drain.
        base_addr = 32'h4000;
        for (int i = 0; i < 10; i++) applyStimulus(i, 16'h0300 + 16'(i));
        startPops = popCount;
        pulseFinish();
        for (int n = 0; n < 100 && popCount - startPops < 7; n++) @(posedge clk);
        checkOutput("reachedWrite7", 64'(popCount - startPops), 64'd7);
        #1 rst = 1;
        tick();
        rst = 0;
        expQ.delete();
        expErr = 0;
        tileOpen = 0;
        checkOutput("midRstReq", 64'(mem_req), 64'd0);
        checkOutput("midRstBusy", 64'(wb_busy), 64'd0);
        checkOutput("midRstErr", 64'(wb_err), 64'd0);
        fullTile(32'h5000, 16'h0050);
        pulseFinish();
        waitDone(1);

        // Beat during drain is dropped and flagged; next tile clears the flag.
        fullTile(32'h6000, 16'h0A00);
        pulseFinish();
        tick();
        in_valid = 1; in_addr = 5'd3; in_data = 16'hDEAD;
        tick();
        in_valid = 0;
        expErr[1] = 1'b1;
        waitDone(0);
        base_addr = 32'h7000;
        applyStimulus(0, 16'h0001);
        checkOutput("newTileErrClr", 64'(wb_err), 64'd0);
        checkOutput("newTileBusy", 64'(wb_busy), 64'd1);
        for (int i = 1; i < SEG; i++) applyStimulus(i, 16'h0001 + 16'(i));
        pulseFinish();
        waitDone(1);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
